// File: rtl/std_pipe_skid_pkg.sv
// Shared definitions for the std pipeline slices.
// State encoding is {main_valid, skid_valid} so the valid flops are the state register.
package std_pipe_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/std_dffer.sv
// Enabled D flip-flop bank with synchronous active-high reset to a fixed value.
module std_dffer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/std_pipe_skid.sv
// Two-entry valid/ready skid buffer: data, valid and ready are all registered.
// The handshake FSM here only drives the enables of the std_dffer storage cells.
module std_pipe_skid
    import std_pipe_skid_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  main_valid_q;
    logic                  skid_valid_q;
    logic                  s_ready_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [DATA_WIDTH-1:0] main_data_d;

    skid_state_e state_q;
    skid_state_e state_d;
    logic [1:0]  state_bits_d;
    logic        up_xfer;
    logic        dn_xfer;
    logic        main_en;
    logic        skid_en;
    logic        main_from_skid;

    assign state_q = skid_state_e'({main_valid_q, skid_valid_q});
    assign up_xfer = s_valid & s_ready_q;
    assign dn_xfer = main_valid_q & m_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (up_xfer) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                end
            end
            ST_BUSY: begin
                if (up_xfer && !dn_xfer) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (up_xfer && dn_xfer) begin
                    main_en = 1'b1;
                end else if (dn_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready is low here, so only the drain of the skid entry can happen
                if (dn_xfer) begin
                    state_d        = ST_BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_comb begin
        state_bits_d = state_d;
        main_data_d  = main_from_skid ? skid_data_q : s_data;
    end

    std_dffer #(.WIDTH(1), .RESET_VALUE(1'b0)) u_main_valid (
        .clk(clk), .reset(reset), .en(1'b1), .d(state_bits_d[1]), .q(main_valid_q)
    );

    std_dffer #(.WIDTH(1), .RESET_VALUE(1'b0)) u_skid_valid (
        .clk(clk), .reset(reset), .en(1'b1), .d(state_bits_d[0]), .q(skid_valid_q)
    );

    std_dffer #(.WIDTH(1), .RESET_VALUE(1'b1)) u_s_ready (
        .clk(clk), .reset(reset), .en(1'b1), .d(~state_bits_d[0]), .q(s_ready_q)
    );

    std_dffer #(.WIDTH(DATA_WIDTH), .RESET_VALUE(DATA_RESET_VALUE)) u_main_data (
        .clk(clk), .reset(reset), .en(main_en), .d(main_data_d), .q(main_data_q)
    );

    std_dffer #(.WIDTH(DATA_WIDTH), .RESET_VALUE(DATA_RESET_VALUE)) u_skid_data (
        .clk(clk), .reset(reset), .en(skid_en), .d(s_data), .q(skid_data_q)
    );

    assign s_ready = s_ready_q;
    assign m_valid = main_valid_q;
    assign m_data  = main_data_q;

    a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
        !(skid_valid_q && !main_valid_q));

endmodule

// File: tb/tb_std_pipe_skid.sv
// Directed and randomised checks of std_pipe_skid against a two-deep FIFO reference model.
module tb_std_pipe_skid;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    int total;
    int bad;

    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] ref_last_main;

    std_pipe_skid #(.DATA_WIDTH(DW), .DATA_RESET_VALUE('0)) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the slice is a FIFO of at most two payloads; ready means "fewer than two held".
    task automatic modelEdge(input logic rst, input logic fl, input logic sv,
                             input logic [DW-1:0] sd, input logic mr);
        logic up;
        logic dn;
        if (rst) begin
            ref_q.delete();
            ref_last_main = '0;
        end else if (fl) begin
            ref_q.delete();
        end else begin
            up = sv && (ref_q.size() < 2);
            dn = mr && (ref_q.size() > 0);
            if (dn) void'(ref_q.pop_front());
            if (up) ref_q.push_back(sd);
            if (ref_q.size() > 0) ref_last_main = ref_q[0];
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, ref_q.size() > 0});
        checkOutput({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, ref_q.size() < 2});
        checkOutput({tag, ".m_data"}, m_data, ref_last_main);
    endtask

    // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic sv,
                                 input logic [DW-1:0] sd, input logic mr, input string tag);
        reset   = rst;
        flush   = fl;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        modelEdge(rst, fl, sv, sd, mr);
        @(negedge clk);
        checkModel(tag);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        ref_last_main = '0;
        reset   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA5;
        m_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles while upstream offers 0xA5
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hA5, 1'b0, "rst0");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hA5, 1'b0, "rst1");
        checkOutput("rst.m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst.s_ready", {31'd0, s_ready}, 32'd1);
        checkOutput("rst.m_data", m_data, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5, 1'b0, "rel");
        checkOutput("rel.m_data", m_data, 32'hA5);
        checkOutput("rel.m_valid", {31'd0, m_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, "rstA");

        // Back-to-back stream with no backpressure
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, DW'(i), 1'b1, "stream");
            checkOutput("stream.m_data", m_data, DW'(i));
            checkOutput("stream.s_ready", {31'd0, s_ready}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "stream_end");
        checkOutput("stream_end.m_valid", {31'd0, m_valid}, 32'd0);

        // Fill to FULL under backpressure, then drain in order
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, "fill0");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, "fill1");
        checkOutput("full.s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("full.m_data", m_data, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12, 1'b0, "full_hold");
        checkOutput("full_hold.m_data", m_data, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "drain0");
        checkOutput("drain0.m_data", m_data, 32'h11);
        checkOutput("drain0.s_ready", {31'd0, s_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "drain1");
        checkOutput("drain1.m_valid", {31'd0, m_valid}, 32'd0);

        // Flush from FULL discards the same-cycle upstream payload
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, "ffill0");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h21, 1'b0, "ffill1");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h22, 1'b0, "flush");
        checkOutput("flush.m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("flush.s_ready", {31'd0, s_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "post_flush");
        checkOutput("post_flush.m_data", m_data, 32'h20);
        checkOutput("post_flush.m_valid", {31'd0, m_valid}, 32'd0);

        // Reset and flush together from FULL
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, "rfill0");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h31, 1'b0, "rfill1");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h32, 1'b1, "rst_flush");
        checkOutput("rst_flush.m_data", m_data, 32'd0);
        checkOutput("rst_flush.m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_flush.s_ready", {31'd0, s_ready}, 32'd1);

        // Random valid/ready traffic against the FIFO model
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom),
                          1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
